bcd_decoder: RTL and testbench
==============================

BCD_DECODER -- requirements
Module: bcd_decoder

Interface
REQ-001 SHALL provide parameter MAX_VAL, default 99, meaning the largest legal decoded value (legal range 0..99).
REQ-002 SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL provide port bcd_in, input, 8 bits: two-digit packed BCD; [7:4] is tens, [3:0] is units.
REQ-005 SHALL provide port in_valid, input, 1 bit: bcd_in is valid.
REQ-006 SHALL provide port in_ready, output, 1 bit: the block accepts input this cycle.
REQ-007 SHALL provide port bin_out, output, 7 bits: decoded binary value.
REQ-008 SHALL provide port err, output, 2 bits: bit0 is invalid digit, bit1 is range exceeded.
REQ-009 SHALL provide port out_valid, output, 1 bit: bin_out and err are valid.
REQ-010 SHALL provide port out_ready, input, 1 bit: the consumer accepts the result.

Function
REQ-011 SHALL implement states IDLE, CHECK, CALC and DONE with transitions IDLE->CHECK->CALC->DONE->IDLE.
REQ-012 SHALL drive in_ready=1 only in IDLE.
REQ-013 SHALL capture bcd_in and move to CHECK on the edge where in_valid and in_ready are both high (edge E0).
REQ-014 SHALL stay in IDLE while in_valid=0.
REQ-015 In CHECK, SHALL flag any nibble above 9 as invalid and register the result; the next edge moves to CALC.
REQ-016 In CALC, SHALL compute tens*10+units using shifts and adds only (tens<<3 + tens<<1 + units), with no multiplier, into 7 bits; the next edge moves to DONE.
REQ-017 SHALL assert out_valid after edge E0+3 and only in DONE, giving a fixed latency of 3 edges.
REQ-018 In DONE, SHALL hold bin_out, err and out_valid stable until out_ready=1; the edge that sees out_ready=1 returns to IDLE.
REQ-019 SHALL accept a new input at the earliest 1 edge after the DONE->IDLE edge, giving a maximum throughput of 1 result per 5 cycles.
REQ-020 On an invalid digit, SHALL drive err=2'b01 and bin_out=0, and SHALL skip the range check.
REQ-021 On valid digits with value > MAX_VAL, SHALL set err[1]=1; bin_out is as defined under Configuration.
REQ-022 On valid digits with value <= MAX_VAL, SHALL drive err=2'b00 and bin_out=value.
REQ-023 SHALL ignore in_valid and bcd_in outside IDLE, with no queuing.
REQ-024 SHALL hold bin_out and err at their last values while out_valid=0.

Reset
REQ-025 While rst_n=0, SHALL force state=IDLE, bin_out=0, err=0, out_valid=0 and in_ready=1.
REQ-026 On reset asserted in CHECK, CALC or DONE, SHALL abort the conversion and produce no out_valid pulse for it.
REQ-027 SHALL make the first capture possible on the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL use macro BCD_DEC_SAT_EN to select range-overflow behaviour.
REQ-029 With BCD_DEC_SAT_EN defined, on range overflow SHALL drive bin_out=MAX_VAL and err=2'b10, indicating saturation.
REQ-030 Without BCD_DEC_SAT_EN, on range overflow SHALL drive bin_out=computed value and err=2'b10.

Structure
REQ-031 SHALL place the following in shared package bcd_pkg: the state enum, BCD_DIGIT_W=4, BCD_MAX_DEC=99, ERR_DIGIT=0 and ERR_RANGE=1.
REQ-032 SHALL instantiate one combinational sub-module, bcd_digit_check: 4-bit digit in, valid flag out, used once per nibble.

Verification
REQ-033 SHALL cover: bcd_in=8'h47, MAX_VAL=99 -> bin_out=47, err=00, out_valid 3 edges after capture.
REQ-034 SHALL cover: bcd_in=8'h3A -> bin_out=0, err=01.
REQ-035 SHALL cover: MAX_VAL=59, bcd_in=8'h75 -> bin_out=75, err=10 without the macro; bin_out=59, err=10 with BCD_DEC_SAT_EN.
REQ-036 SHALL cover: result 47 in DONE, out_ready=0 for 5 cycles, in_valid=1 with 8'h12 -> in_ready=0 and bin_out stable at 47; after out_ready=1, 8'h12 is accepted and 12 is output.
REQ-037 SHALL cover: rst_n pulsed low during CALC -> out_valid never asserts and in_ready=1 immediately.
REQ-038 SHALL cover boundaries: 8'h00 -> 0; 8'h99 -> 99; 8'h59 with MAX_VAL=59 -> 59, err=00.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the two-digit BCD decoder.
//   state_t      : controller state (IDLE -> CHECK -> CALC -> DONE -> IDLE)
//   BCD_DIGIT_W  : width of one BCD digit
//   BCD_MAX_DEC  : largest value two BCD digits can represent
//   ERR_DIGIT    : err bit index, a nibble was not a decimal digit
//   ERR_RANGE    : err bit index, the decoded value exceeded MAX_VAL
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_MAX_DEC = 99;
  localparam int ERR_DIGIT   = 0;
  localparam int ERR_RANGE   = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    CALC  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_digit_check.sv
// Combinational legality check for one BCD digit.
//   digit : 4-bit nibble to check
//   ok    : 1 when the nibble is a decimal digit (0..9)
module bcd_digit_check
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic                   ok
);

  assign ok = (digit <= 4'd9);

endmodule

// File: rtl/bcd_decoder.sv
// Two-digit packed BCD to binary decoder with valid/ready on both sides.
//
// Ports:
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   bcd_in     : packed BCD, [7:4] tens, [3:0] units
//   in_valid   : bcd_in is valid
//   in_ready   : block accepts input this cycle (only in IDLE)
//   bin_out    : decoded binary value
//   err        : bit ERR_DIGIT = invalid digit, bit ERR_RANGE = value > MAX_VAL
//   out_valid  : bin_out and err are valid
//   out_ready  : consumer accepts the result
//   fsm_state  : current controller state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds data stable while valid is high and ready is
// low; in_ready does not depend on in_valid, and out_valid does not depend
// on out_ready.
//
// Configuration macro BCD_DEC_SAT_EN: when defined, a range overflow
// saturates bin_out to MAX_VAL; otherwise bin_out carries the computed value.
// err is 2'b10 on overflow in both builds.
//
// Timing: capture on edge E0, digit check registered on E0+1, value computed
// on E0+2 (entering DONE), result presented with out_valid on E0+3. The edge
// that sees out_valid and out_ready both high returns to IDLE.
module bcd_decoder
  import bcd_pkg::*;
#(
  parameter int MAX_VAL = BCD_MAX_DEC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bcd_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [6:0] bin_out,
  output logic [1:0] err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] fsm_state
);

  localparam logic [6:0] MAX_VAL7 = 7'(MAX_VAL);

  state_t     state;
  logic [7:0] cap;
  logic       digit_bad;
  logic [6:0] res_bin;
  logic [1:0] res_err;
  logic       tens_ok;
  logic       units_ok;
  logic [6:0] tens7;
  logic [6:0] units7;
  logic [6:0] sum;

  bcd_digit_check u_tens_check (
    .digit (cap[7:4]),
    .ok    (tens_ok)
  );

  bcd_digit_check u_units_check (
    .digit (cap[3:0]),
    .ok    (units_ok)
  );

  // tens*10 built as tens*8 + tens*2; only meaningful for legal digits,
  // where the result never exceeds 99 and fits in 7 bits.
  assign tens7  = {3'b000, cap[7:4]};
  assign units7 = {3'b000, cap[3:0]};
  assign sum    = (tens7 << 3) + (tens7 << 1) + units7;

  assign in_ready  = (state == IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cap       <= 8'h00;
      digit_bad <= 1'b0;
      res_bin   <= 7'd0;
      res_err   <= 2'b00;
      bin_out   <= 7'd0;
      err       <= 2'b00;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cap   <= bcd_in;
            state <= CHECK;
          end
        end
        CHECK: begin
          digit_bad <= !(tens_ok && units_ok);
          state     <= CALC;
        end
        CALC: begin
          res_err <= 2'b00;
          if (digit_bad) begin
            // Invalid digit wins; the range check is not applied.
            res_bin            <= 7'd0;
            res_err[ERR_DIGIT] <= 1'b1;
          end else if (sum > MAX_VAL7) begin
            res_err[ERR_RANGE] <= 1'b1;
`ifdef BCD_DEC_SAT_EN
            res_bin <= MAX_VAL7;
`else
            res_bin <= sum;
`endif
          end else begin
            res_bin <= sum;
          end
          state <= DONE;
        end
        DONE: begin
          // First DONE cycle publishes the result; outputs then hold until
          // the consumer takes it.
          if (!out_valid) begin
            bin_out   <= res_bin;
            err       <= res_err;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_decoder.sv
// Bench for bcd_decoder: two instances (MAX_VAL 99 and 59) share stimulus;
// a driver pushes expected results, a negedge monitor pops and compares.
module tb_bcd_decoder;

  localparam int W = 50;  // {due_cycle[31:0], res99[8:0], res59[8:0]}

  logic       clk;
  logic       rst_n;
  logic [7:0] bcd_in;
  logic       in_valid;
  logic       out_ready;
  logic       in_ready  [2];
  logic [6:0] bin_out   [2];
  logic [1:0] err       [2];
  logic       out_valid [2];
  logic [1:0] fsm_state [2];

  logic [W-1:0] exp_q[$];
  logic [8:0]   last_res [2];
  logic         ov_prev;
  int           cyc;
  int           last_cap;
  int           n_vec;
  int           n_err;

  bcd_decoder #(.MAX_VAL(99)) u_dut99 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd_in    (bcd_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready[0]),
    .bin_out   (bin_out[0]),
    .err       (err[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready),
    .fsm_state (fsm_state[0])
  );

  bcd_decoder #(.MAX_VAL(59)) u_dut59 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd_in    (bcd_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready[1]),
    .bin_out   (bin_out[1]),
    .err       (err[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready),
    .fsm_state (fsm_state[1])
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Returns {err, bin} from the decimal meaning of the two nibbles.
  function automatic logic [8:0] model(input logic [7:0] b, input int maxv);
    int t;
    int u;
    int v;
    t = int'(b) / 16;
    u = int'(b) % 16;
    if (t > 9 || u > 9) return {2'b01, 7'd0};
    v = t * 10 + u;
    if (v > maxv) begin
`ifdef BCD_DEC_SAT_EN
      return {2'b10, 7'(maxv)};
`else
      return {2'b10, 7'(v)};
`endif
    end
    return {2'b00, 7'(v)};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [8:0]   ex;
    if (!rst_n) begin
      exp_q.delete();
      ov_prev = 1'b0;
      for (int i = 0; i < 2; i++) begin
        last_res[i] = 9'd0;
        chk("rst_out_valid", int'(out_valid[i]), 0);
        chk("rst_in_ready",  int'(in_ready[i]), 1);
        chk("rst_bin_out",   int'(bin_out[i]), 0);
        chk("rst_err",       int'(err[i]), 0);
      end
    end else begin
      chk("out_valid_pair", int'(out_valid[1]), int'(out_valid[0]));
      if (out_valid[0]) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", int'(out_valid[0]), 0);
        end else begin
          e = exp_q[0];
          if (!ov_prev) chk("latency_cycle", cyc, int'(e[49:18]));
          for (int i = 0; i < 2; i++) begin
            ex = (i == 0) ? e[17:9] : e[8:0];
            chk(i == 0 ? "bin_out_99" : "bin_out_59", int'(bin_out[i]), int'(ex[6:0]));
            chk(i == 0 ? "err_99" : "err_59", int'(err[i]), int'(ex[8:7]));
          end
          if (out_ready) begin
            last_res[0] = e[17:9];
            last_res[1] = e[8:0];
            void'(exp_q.pop_front());
          end
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          chk("hold_bin_out", int'(bin_out[i]), int'(last_res[i][6:0]));
          chk("hold_err", int'(err[i]), int'(last_res[i][8:7]));
        end
      end
      ov_prev = out_valid[0];
    end
  end

  // ---------------- driver tasks ----------------
  // Called between rising edges; presents b and waits (bounded) for in_ready.
  task automatic send(input logic [7:0] b);
    int k;
    k = 0;
    bcd_in   = b;
    in_valid = 1'b1;
    while (!in_ready[0] && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready[0]) begin
      chk("accept_timeout", int'(in_ready[0]), 1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back({32'(cyc + 4), model(b, 99), model(b, 59)});
      last_cap = cyc + 1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      bcd_in   = 8'($urandom);
    end
  endtask

  // Waits until the scoreboard is empty; with rnd, out_ready and garbage
  // input toggle randomly while the block is busy.
  task automatic drain(input bit rnd);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      if (rnd && k < 20) begin
        out_ready = 1'($urandom_range(0, 1));
        in_valid  = 1'($urandom_range(0, 1));
        bcd_in    = 8'($urandom);
      end else begin
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
      k++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] dir_vec [10] = '{8'h47, 8'h3A, 8'h75, 8'h00, 8'h99,
                               8'h59, 8'hA3, 8'hFF, 8'h60, 8'h5A};

  initial begin
    int c1;
    int k;
    logic [7:0] b;
    n_vec    = 0;
    n_err    = 0;
    last_cap = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    bcd_in   = 8'h00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", int'(in_ready[0]), 1);
    chk("reset_out_valid", int'(out_valid[0]), 0);
    rst_n = 1'b1;

    // Directed values, including boundaries and both error kinds.
    foreach (dir_vec[i]) begin
      send(dir_vec[i]);
      drain(1'b0);
    end

    // Back-to-back acceptance with the consumer always ready.
    send(8'h21);
    c1 = last_cap;
    send(8'h34);
    chk("throughput_cycles", last_cap - c1, 5);
    drain(1'b0);

    // Result held in DONE while the consumer stalls; new input refused.
    out_ready = 1'b0;
    send(8'h47);
    k = 0;
    while (!out_valid[0] && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("done_reached", int'(out_valid[0]), 1);
    bcd_in   = 8'h12;
    in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("busy_in_ready", int'(in_ready[0]), 0);
      chk("busy_bin_out", int'(bin_out[0]), 47);
    end
    out_ready = 1'b1;
    send(8'h12);
    drain(1'b0);

    // Reset during CALC aborts the conversion.
    send(8'h47);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", int'(in_ready[0]), 1);
    chk("abort_out_valid", int'(out_valid[0]), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Capture on the first edge after reset release.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(8'h99);
    drain(1'b0);

    // Randomized traffic, mostly legal digits.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) != 0)
        b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      else
        b = 8'($urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      send(b);
      drain(1'b1);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
